// File: rtl/mux_pkg.sv
// Shared definitions for the 4x1 round-robin channel merger.
//   NUM_CH  : number of input channels
//   SEL_W   : width of a channel index
//   sel_t   : channel index type (also the out_sel tag)
//   state_t : output register occupancy (EMPTY / FULL)
package mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/mux_4x1_rr_if.sv
// Handshake bundle for mux_4x1_rr.
//   in_valid/in_data/in_ready : four producer channels, channel i data at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_sel/out_ready : merged consumer channel, tagged with source index
// Modports: master = producers/consumer side (testbench), slave = the merger.
interface mux_4x1_rr_if import mux_pkg::*; #(
  parameter int WIDTH = 8
) ();
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  sel_t                    out_sel;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way arbiter.
//   in_valid  : request vector
//   ptr       : channel with highest priority this cycle
//   grant_vld : some request is set
//   grant_idx : first requesting channel found searching upward from ptr, wrapping 3 -> 0
// Build option FIXED_PRIO_EN: search always starts at channel 0 and ptr is ignored.
module rr_arbiter_4 import mux_pkg::*; (
  input  logic [NUM_CH-1:0] in_valid,
  input  sel_t              ptr,
  output logic              grant_vld,
  output sel_t              grant_idx
);

  sel_t start;

`ifdef FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start      = ptr;
`endif

  sel_t cand;

  // Walk from the farthest offset down to offset 0 so the nearest requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = start;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = start + sel_t'(k);
      if (in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4x1_rr.sv
// 4-input, 1-output channel merger with a registered output stage.
// Arbitrates round-robin (or fixed priority with FIXED_PRIO_EN defined), forwards
// one beat per cycle and tags each beat with its source channel in out_sel.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_4x1_rr_if slave modport (per-channel in_*, merged out_*)
//
// state | meaning
// EMPTY | output register holds no beat (out_valid=0)
// FULL  | output register holds a beat  (out_valid=1)
module mux_4x1_rr import mux_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  mux_4x1_rr_if.slave  bus
);

  state_t state, state_nxt;
  logic   load_en;
  logic   xfer_in;
  logic   grant_vld;
  sel_t   grant_idx;
  sel_t   rr_ptr;
  logic [WIDTH-1:0] grant_data;

`ifdef FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (xfer_in) rr_ptr <= grant_idx + sel_t'(1);
  end
`endif

  rr_arbiter_4 u_arb (
    .in_valid  (bus.in_valid),
    .ptr       (rr_ptr),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // rst_n is folded in so in_ready drops the moment reset asserts.
  assign load_en = rst_n && ((state == EMPTY) || bus.out_ready);
  assign xfer_in = load_en && grant_vld;

  always_comb begin
    bus.in_ready            = '0;
    bus.in_ready[grant_idx] = xfer_in;
  end

  always_comb begin
    grant_data = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer_in)            state_nxt = FULL;
    else if (bus.out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_sel  <= '0;
    end else if (xfer_in) begin
      bus.out_data <= grant_data;
      bus.out_sel  <= grant_idx;
    end
  end

  assign bus.out_valid = (state == FULL);

endmodule

// File: doc/mux_4x1_rr.md
Name: mux_4x1_rr

Overview:
- 4-input, 1-output channel merger with valid/ready handshakes; the gather-side counterpart of the team's 1x4 demultiplexer.
- Sits where four producer channels converge onto one consumer. Arbitrates round-robin and forwards one beat per cycle through a registered output stage.
- Tags each output beat with its source channel index, so a downstream 1x4 demux can re-route it.

Parameters:
- WIDTH, 8, data width of every input channel and the output.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel ready; combinational, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  2  registered source channel index of out_data.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
- load_en = !out_valid || out_ready.
- Grant (combinational):
  - Search in_valid starting at rr_ptr, wrapping 3 -> 0.
  - The first set bit is the grant index g; no set bit means no grant.
- in_ready[i] = load_en && grant && (i == g). At most one bit of in_ready is high.
- Input transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod 4 (2-bit natural wrap).
- Output transfer: out_valid && out_ready.
  - If an input transfer happens in the same cycle, the register reloads: out_valid stays 1, giving back-to-back beats.
  - Otherwise out_valid <= 0.
- Latency: input accepted at edge N appears on the outputs after edge N; 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - All in_ready=0.
  - out_data and out_sel hold stable.
  - rr_ptr holds.
- Fairness: with all four channels continuously valid and out_ready=1, the grant sequence is 0,1,2,3,0,... Each channel waits at most 3 beats.
- No in_valid set: no grant; rr_ptr holds; out_valid falls after the pending beat is taken.
- A producer may drop in_valid before it is granted. The arbiter makes no assumption of input stability, because the grant is recomputed every cycle.
- Reset mid-operation: any pending beat is discarded, rr_ptr returns to 0, and in_ready drops immediately (async).
- States: EMPTY (out_valid=0) and FULL (out_valid=1). out_valid itself is the state bit.
  - EMPTY -> FULL on input transfer.
  - FULL -> EMPTY on output transfer without input transfer.
  - FULL -> FULL on a stall, or on a simultaneous output and input transfer.

Optional Feature:
- Macro FIXED_PRIO_EN.
- Defined:
  - Grant search always starts at channel 0, so channel 0 has highest priority and channel 3 lowest.
  - rr_ptr is not implemented.
  - With all channels valid, only channel 0 is served.
- Undefined: round-robin as specified above.
- All ports and latency are identical in both builds.

Decomposition:
- Package mux_pkg:
  - NUM_CH=4.
  - SEL_W=2.
  - Typedef sel_t (logic [SEL_W-1:0]).
- One sub-module, rr_arbiter_4: in_valid and ptr in; grant_vld and grant_idx out. Purely combinational. It contains the FIXED_PRIO_EN switch.
- The datapath register, rr_ptr and the handshake stay in mux_4x1_rr.

Test Plan:
- Reset check: assert rst_n=0 mid-stream while out_valid=1. Required: out_valid=0, out_data=0, out_sel=0 and in_ready=4'b0000 immediately. After release with in_valid=4'b1111, channel 0 is granted first.
- Single channel: in_valid=4'b0100, ch2 data=8'hA5, out_ready=1. Required: in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- Round-robin: in_valid=4'b1111 held, ch0..3 data = 8'h10, 8'h21, 8'h32, 8'h43, out_ready=1. Required: out_sel sequence 0,1,2,3,0 on consecutive cycles with matching data and no bubbles.
- Backpressure: FULL with out_data=8'h21, out_sel=1, out_ready=0 for 3 cycles. Required: in_ready=0, outputs stable and rr_ptr unchanged. When out_ready=1, the next grant is channel 2.
- Sparse wrap: in_valid=4'b1001, rr_ptr=1. Required: grant ch3 then ch0 (wrap). With FIXED_PRIO_EN defined the same stimulus grants ch0 every beat.
- Randomised: 1000 cycles of random in_valid and out_ready. A scoreboard checks:
  - every accepted beat emerges exactly once, in acceptance order, with the correct out_sel;
  - in_ready is never multi-hot.
